mod_counter: RTL and testbench
==============================

# mod_counter

Parametrised up/down modulo counter generalising the team's fixed 4-bit free-running counter. It adds configurable width and modulus, direction control, count enable, parallel load, and a wrap-or-saturate mode. It also provides terminal-count and wrap/saturate status for chaining counters and driving timers. It is a single-clock leaf block used by display, timer and sequencing logic.

## Interface
- `WIDTH`, default 4: counter width in bits; legal range 2..32.
- `MODULUS`, default 16: count range is 0..MODULUS-1; legal range 2..2^WIDTH.
- `SATURATE`, default 0: 0 = wrap at range ends; 1 = hold at range ends.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `clear` input 1: synchronous soft clear to 0; does not clear `sat`.
- `load` input 1: parallel load strobe.
- `load_val` input WIDTH: value to load.
- `en` input 1: count enable.
- `up` input 1: direction; 1 = increment, 0 = decrement.
- `count` output WIDTH: current count (registered).
- `tc` output 1: terminal count (combinational).
- `wrap` output 1: registered one-cycle pulse.
- `sat` output 1: registered sticky saturation flag.

## Operation
- Define MAX = MODULUS-1.
- Per-edge priority: `reset` > `clear` > `load` > `en`. Only the highest-priority active input acts.
- `reset`: count=0, wrap=0, sat=0.
- `clear`: count=0, wrap=0, sat unchanged.
- `load`:
  - count = load_val if load_val ≤ MAX, else count = MAX (clamped).
  - Load also clears `sat`; wrap=0.
- `en`=1, `up`=1:
  - If count<MAX: count+1.
  - If count==MAX and SATURATE=0: count=0, wrap=1.
  - If count==MAX and SATURATE=1: count holds at MAX, sat=1.
- `en`=1, `up`=0:
  - If count>0: count−1.
  - If count==0 and SATURATE=0: count=MAX, wrap=1.
  - If count==0 and SATURATE=1: count holds at 0, sat=1.
- `en`=0: count holds; wrap=0.
- `wrap` is registered and high only in the cycle following a wrapping edge, i.e. while `count` shows the wrapped value. It is never asserted when SATURATE=1.
- `tc` = en & ((up & count==MAX) | (~up & count==0)). It is independent of `load`, `clear` and `reset`, so it can serve as the `en` of a cascaded stage.
- Arithmetic is done in WIDTH bits. When MODULUS = 2^WIDTH, wrap equals natural overflow. Out-of-range states are unreachable because load clamps.
- Direction may change on any cycle; the new direction takes effect at the same edge.

## Timing
- Reset values: count=0, wrap=0, sat=0. `tc` = en & ~up after reset, since count==0.
- Latency from `en`, `load` or `clear` sampled at edge N to the new `count` is 1 cycle (visible after edge N).
- `tc` is combinational from `en`, `up` and `count` in the same cycle; there is no registered delay.
- `sat` sets at the saturating edge and stays set until `load` or `reset`.
- Reset mid-count: count is 0 after the next edge regardless of `load`, `en` or `clear`.
- Simultaneous `load` and `en` at the terminal value: the load wins, no wrap pulse, and `sat` is cleared.

## Test plan
- Wrap up (WIDTH=4, MODULUS=10, SATURATE=0): reset, then en=1, up=1 for 12 cycles. Required: count 0..9, 0, 1. `wrap` high exactly in the cycle count=0 after 9. `tc`=1 while count=9.
- Wrap down (same config): reset, en=1, up=0. Required: count 0→9→8. `wrap` pulses with count=9. `tc`=1 in the first cycle (count=0).
- Saturate (SATURATE=1, MODULUS=10): load 8, then en=1, up=1 for 4 cycles. Required: count 9,9,9,9; `sat`=1 from the first hold onward; `wrap` stays 0. Then load 3: count=3, sat=0.
- Load clamp and priority: load_val=15 with MODULUS=10 → count=9. Assert load=1 with load_val=2 and en=1 at count=9 → count=2, no wrap pulse. Assert clear and load together → count=0.
- Reset mid-operation: at count=5, assert reset together with load=1 (load_val=7) and en=1 → count=0, wrap=0, sat=0 after one edge. Counting resumes on the next enabled edge.
- Cascade: two instances (MODULUS=10), with the low stage's `tc` driving the high stage's `en`; run 25 enabled cycles from reset. Required: high=2, low=5.

Source files
------------

// File: rtl/mod_counter.sv
// Parametrised up/down modulo counter with load, soft clear, wrap-or-saturate
// behaviour and a combinational terminal-count output for cascading.
module mod_counter #(
  parameter int unsigned      WIDTH    = 4,
  parameter longint unsigned  MODULUS  = 16,
  parameter bit               SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             sat
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 64'd1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             sat_q, sat_d;
  logic             at_max, at_zero;

  assign at_max  = (count_q == MAX);
  assign at_zero = (count_q == '0);

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    sat_d   = sat_q;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = (load_val > MAX) ? MAX : load_val;
      sat_d   = 1'b0;
    end else if (en) begin
      // At a range end: either wrap to the opposite end or hold and flag.
      if (up) begin
        if (!at_max) begin
          count_d = count_q + WIDTH'(1);
        end else if (SATURATE) begin
          sat_d = 1'b1;
        end else begin
          count_d = '0;
          wrap_d  = 1'b1;
        end
      end else begin
        if (!at_zero) begin
          count_d = count_q - WIDTH'(1);
        end else if (SATURATE) begin
          sat_d = 1'b1;
        end else begin
          count_d = MAX;
          wrap_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      sat_q   <= sat_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign sat   = sat_q;
  assign tc    = en & ((up & at_max) | (~up & at_zero));

endmodule

// File: tb/tb_mod_counter.sv
// Directed bench for mod_counter: wrap, saturate, load/clear priority,
// mid-count reset, natural overflow and a two-stage decimal cascade.
module tb_mod_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Instance A: MODULUS=10, wrapping
  logic       a_reset, a_clear, a_load, a_en, a_up;
  logic [3:0] a_load_val, a_count;
  logic       a_tc, a_wrap, a_sat;
  // Instance B: MODULUS=10, saturating
  logic       b_reset, b_clear, b_load, b_en, b_up;
  logic [3:0] b_load_val, b_count;
  logic       b_tc, b_wrap, b_sat;
  // Cascade pair
  logic       c_reset, c_en;
  logic [3:0] lo_count, hi_count;
  logic       lo_tc, lo_wrap, lo_sat, hi_tc, hi_wrap, hi_sat;
  // Instance D: defaults (4 bits, MODULUS=16)
  logic       d_reset, d_load, d_en;
  logic [3:0] d_load_val, d_count;
  logic       d_tc, d_wrap, d_sat;

  mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_a (
    .clk(clk), .reset(a_reset), .clear(a_clear), .load(a_load), .load_val(a_load_val),
    .en(a_en), .up(a_up), .count(a_count), .tc(a_tc), .wrap(a_wrap), .sat(a_sat));

  mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_b (
    .clk(clk), .reset(b_reset), .clear(b_clear), .load(b_load), .load_val(b_load_val),
    .en(b_en), .up(b_up), .count(b_count), .tc(b_tc), .wrap(b_wrap), .sat(b_sat));

  mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_lo (
    .clk(clk), .reset(c_reset), .clear(1'b0), .load(1'b0), .load_val(4'd0),
    .en(c_en), .up(1'b1), .count(lo_count), .tc(lo_tc), .wrap(lo_wrap), .sat(lo_sat));

  mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_hi (
    .clk(clk), .reset(c_reset), .clear(1'b0), .load(1'b0), .load_val(4'd0),
    .en(lo_tc), .up(1'b1), .count(hi_count), .tc(hi_tc), .wrap(hi_wrap), .sat(hi_sat));

  mod_counter u_d (
    .clk(clk), .reset(d_reset), .clear(1'b0), .load(d_load), .load_val(d_load_val),
    .en(d_en), .up(1'b1), .count(d_count), .tc(d_tc), .wrap(d_wrap), .sat(d_sat));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    a_reset = 1; a_clear = 0; a_load = 0; a_load_val = 0; a_en = 0; a_up = 1;
    b_reset = 1; b_clear = 0; b_load = 0; b_load_val = 0; b_en = 0; b_up = 1;
    c_reset = 1; c_en = 0;
    d_reset = 1; d_load = 0; d_load_val = 0; d_en = 0;
    step();
    check("A reset count", 32'(a_count), 0);
    check("A reset wrap", 32'(a_wrap), 0);
    check("A reset sat", 32'(a_sat), 0);
    check("A reset tc en=0", 32'(a_tc), 0);
    check("B reset count", 32'(b_count), 0);
    a_reset = 0; b_reset = 0; c_reset = 0; d_reset = 0;

    // Wrap up: 0..9,0,1
    a_en = 1; a_up = 1;
    for (int i = 0; i < 12; i++) begin
      #1;
      check($sformatf("up count[%0d]", i), 32'(a_count), 32'(i % 10));
      check($sformatf("up wrap[%0d]", i), 32'(a_wrap), (i == 10) ? 1 : 0);
      check($sformatf("up tc[%0d]", i), 32'(a_tc), (i % 10 == 9) ? 1 : 0);
      step();
    end
    check("up after 12", 32'(a_count), 2);

    // Wrap down: 0 -> 9 -> 8
    a_en = 0; a_reset = 1; step(); a_reset = 0;
    a_en = 1; a_up = 0; #1;
    check("down tc at 0", 32'(a_tc), 1);
    step();
    check("down count 9", 32'(a_count), 9);
    check("down wrap", 32'(a_wrap), 1);
    check("down tc at 9", 32'(a_tc), 0);
    step();
    check("down count 8", 32'(a_count), 8);
    check("down wrap clear", 32'(a_wrap), 0);

    // Load clamp and priority
    a_en = 0; a_load = 1; a_load_val = 15; step();
    check("clamp count", 32'(a_count), 9);
    a_load = 0; a_en = 1; a_up = 1; #1;
    check("tc at 9 before load", 32'(a_tc), 1);
    a_load = 1; a_load_val = 2; step();
    check("load beats en", 32'(a_count), 2);
    check("load no wrap", 32'(a_wrap), 0);
    a_en = 0; a_clear = 1; a_load = 1; a_load_val = 7; step();
    check("clear beats load", 32'(a_count), 0);
    a_clear = 0; a_load = 0;
    a_en = 0; #1;
    check("hold en=0 tc", 32'(a_tc), 0);
    step();
    check("hold en=0 count", 32'(a_count), 0);

    // Reset mid-operation
    a_load = 1; a_load_val = 5; step();
    check("mid load 5", 32'(a_count), 5);
    a_reset = 1; a_load_val = 7; a_en = 1; a_up = 1; step();
    check("mid reset count", 32'(a_count), 0);
    check("mid reset wrap", 32'(a_wrap), 0);
    check("mid reset sat", 32'(a_sat), 0);
    a_reset = 0; a_load = 0; step();
    check("resume count", 32'(a_count), 1);

    // Saturate up
    b_load = 1; b_load_val = 8; step();
    check("sat load 8", 32'(b_count), 8);
    b_load = 0; b_en = 1; b_up = 1;
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("sat count[%0d]", k), 32'(b_count), 9);
      check($sformatf("sat flag[%0d]", k), 32'(b_sat), (k >= 2) ? 1 : 0);
      check($sformatf("sat wrap[%0d]", k), 32'(b_wrap), 0);
    end
    b_en = 0; b_load = 1; b_load_val = 3; step();
    check("sat reload count", 32'(b_count), 3);
    check("sat reload flag", 32'(b_sat), 0);
    // Saturate down, then clear keeps the flag
    b_load_val = 0; step();
    b_load = 0; b_en = 1; b_up = 0; step();
    check("satdn count", 32'(b_count), 0);
    check("satdn flag", 32'(b_sat), 1);
    check("satdn wrap", 32'(b_wrap), 0);
    b_en = 0; b_clear = 1; step();
    check("clear keeps sat", 32'(b_sat), 1);
    b_clear = 0; b_reset = 1; step();
    check("reset clears sat", 32'(b_sat), 0);
    b_reset = 0;

    // Natural overflow at MODULUS = 2^WIDTH
    d_load = 1; d_load_val = 15; step();
    check("D load 15", 32'(d_count), 15);
    d_load = 0; d_en = 1; step();
    check("D overflow count", 32'(d_count), 0);
    check("D overflow wrap", 32'(d_wrap), 1);
    d_en = 0;

    // Cascade: 25 enabled edges -> 25
    c_en = 1;
    for (int i = 0; i < 25; i++) step();
    c_en = 0;
    check("cascade low", 32'(lo_count), 5);
    check("cascade high", 32'(hi_count), 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
